// File: rtl/pipe_perf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : pipe_perf_pkg                                            |
// | Brief   : Shared types and constants for the pipeline perf monitor |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package pipe_perf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } perf_state_e;

  // Event channel assignments used by the CPU top when wiring event_i.
  localparam int unsigned EV_STALL  = 0;
  localparam int unsigned EV_FLUSH  = 1;
  localparam int unsigned EV_BRANCH = 2;
  localparam int unsigned EV_JUMP   = 3;

  localparam int unsigned DEFAULT_CNT_W = 32;

endpackage
`default_nettype wire

// File: rtl/perf_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : perf_sat_counter                                         |
// | Brief   : Saturating up-counter with clear and sticky overflow     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module perf_sat_counter
  import pipe_perf_pkg::*;
#(
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             w_at_max;

  assign w_at_max = &r_cnt;

  // An increment at all-ones holds the value and latches overflow instead.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (inc_i) begin
      if (w_at_max) begin
        r_ovf <= 1'b1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign cnt_o = r_cnt;
  assign ovf_o = r_ovf;

endmodule
`default_nettype wire

// File: rtl/pipe_perf_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : pipe_perf_monitor                                        |
// | Brief   : Run-cycle and qualified-event counters with cycle limit  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module pipe_perf_monitor
  import pipe_perf_pkg::*;
#(
  parameter int unsigned NUM_EVENTS = 4,
  parameter int unsigned CNT_W      = DEFAULT_CNT_W,
  parameter int unsigned SEL_W      = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic [NUM_EVENTS-1:0] event_mask_i,
  input  logic [CNT_W-1:0]      limit_i,
  input  logic                  clear_i,
  input  logic [SEL_W-1:0]      rd_sel_i,
  output logic [CNT_W-1:0]      rd_data_o,
  output logic [NUM_EVENTS:0]   ovf_o,
  output logic                  running_o,
  output logic                  halt_o
);

  perf_state_e r_state;
  perf_state_e w_state_nxt;

  logic             w_in_run;
  logic [CNT_W-1:0] w_cnt [0:NUM_EVENTS];
  logic [CNT_W-1:0] w_cyc_plus1;
  logic             w_limit_hit;
  logic [CNT_W-1:0] w_rd_mux;
  logic [CNT_W-1:0] r_rd_data;
  logic             r_running;
  logic             r_halt;

  assign w_in_run = (r_state == RUN);

  // Event counters occupy indices 0..NUM_EVENTS-1; the cycle counter sits last.
  generate
    for (genvar k = 0; k < NUM_EVENTS; k++) begin : g_ev_cnt
      perf_sat_counter #(
        .CNT_W (CNT_W)
      ) u_ev_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clear_i),
        .inc_i (w_in_run & event_i[k] & event_mask_i[k]),
        .cnt_o (w_cnt[k]),
        .ovf_o (ovf_o[k])
      );
    end
  endgenerate

  perf_sat_counter #(
    .CNT_W (CNT_W)
  ) u_cyc_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clear_i),
    .inc_i (w_in_run),
    .cnt_o (w_cnt[NUM_EVENTS]),
    .ovf_o (ovf_o[NUM_EVENTS])
  );

  // A saturated cycle counter wraps to 0 here, which never equals a non-zero limit.
  assign w_cyc_plus1 = w_cnt[NUM_EVENTS] + CNT_W'(1);
  assign w_limit_hit = (limit_i != '0) && (w_cyc_plus1 == limit_i);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (start_i) w_state_nxt = RUN;
      RUN: begin
        if (w_limit_hit)   w_state_nxt = HALT;
        else if (!start_i) w_state_nxt = IDLE;
      end
      HALT:    w_state_nxt = HALT;
      default: w_state_nxt = IDLE;
    endcase
    if (clear_i) w_state_nxt = IDLE;
  end

  always_comb begin
    w_rd_mux = '0;
    for (int unsigned k = 0; k <= NUM_EVENTS; k++) begin
      if (rd_sel_i == SEL_W'(k)) w_rd_mux = w_cnt[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
      r_halt    <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == RUN);
      r_halt    <= (w_state_nxt == HALT);
      r_rd_data <= w_rd_mux;
    end
  end

  assign rd_data_o = r_rd_data;
  assign running_o = r_running;
  assign halt_o    = r_halt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_perf_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_pipe_perf_monitor                                     |
// | Brief   : Directed self-checking bench for pipe_perf_monitor       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_pipe_perf_monitor;
  import pipe_perf_pkg::*;

  localparam int unsigned NE    = 4;
  localparam int unsigned CW    = 8;
  localparam int unsigned SW    = 5;
  localparam int unsigned SEL_C = NE;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [NE-1:0] event_i = '0;
  logic [NE-1:0] event_mask_i = '0;
  logic [CW-1:0] limit_i = '0;
  logic          clear_i = 1'b0;
  logic [SW-1:0] rd_sel_i = '0;
  logic [CW-1:0] rd_data_o;
  logic [NE:0]   ovf_o;
  logic          running_o;
  logic          halt_o;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_perf_monitor #(
    .NUM_EVENTS (NE),
    .CNT_W      (CW),
    .SEL_W      (SW)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .event_i      (event_i),
    .event_mask_i (event_mask_i),
    .limit_i      (limit_i),
    .clear_i      (clear_i),
    .rd_sel_i     (rd_sel_i),
    .rd_data_o    (rd_data_o),
    .ovf_o        (ovf_o),
    .running_o    (running_o),
    .halt_o       (halt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Only used while counters are frozen (IDLE with start low, or HALT).
  task automatic read_cnt(input int sel, output logic [CW-1:0] val);
    rd_sel_i = SW'(sel);
    tick();
    val = rd_data_o;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  logic [CW-1:0] v;

  initial begin
    // Reset state
    ticks(2);
    rst_i = 1'b0;
    check_eq("rst_running", running_o, 0);
    check_eq("rst_halt", halt_o, 0);
    check_eq("rst_ovf", ovf_o, 0);
    check_eq("rst_rd", rd_data_o, 0);

    // Reset mid-RUN
    rd_sel_i = SW'(SEL_C);
    start_i = 1'b1;
    ticks(10);
    check_eq("midrun_running", running_o, 1);
    check_eq("midrun_rd_cyc", rd_data_o, 8);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    start_i = 1'b0;
    check_eq("midrst_running", running_o, 0);
    check_eq("midrst_halt", halt_o, 0);
    check_eq("midrst_rd", rd_data_o, 0);
    read_cnt(SEL_C, v);
    check_eq("midrst_cyc", v, 0);

    // Limit halt at 30 with ev0 on counting cycles 5..9
    limit_i = 8'd30;
    event_mask_i = 4'b0001;
    start_i = 1'b1;
    tick();
    check_eq("lim_enter_run", running_o, 1);
    for (int c = 1; c <= 30; c++) begin
      event_i = (c >= 5 && c <= 9) ? 4'b0001 : 4'b0000;
      tick();
      if (c == 29) check_eq("lim_halt_early", halt_o, 0);
    end
    check_eq("lim_halt", halt_o, 1);
    check_eq("lim_running", running_o, 0);
    event_i = 4'b1111;
    ticks(5);
    check_eq("lim_halt_held", halt_o, 1);
    read_cnt(SEL_C, v);
    check_eq("lim_cyc", v, 30);
    read_cnt(0, v);
    check_eq("lim_ev0", v, 5);
    read_cnt(1, v);
    check_eq("lim_ev1", v, 0);
    read_cnt(3, v);
    check_eq("lim_ev3", v, 0);
    check_eq("lim_ovf", ovf_o, 0);

    // Clear in HALT beats start and events
    rd_sel_i = SW'(SEL_C);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    event_i = 4'b0000;
    check_eq("clr_halt", halt_o, 0);
    check_eq("clr_running", running_o, 0);
    check_eq("clr_ovf", ovf_o, 0);
    tick();
    check_eq("clr_then_run", running_o, 1);
    check_eq("clr_cyc_zero", rd_data_o, 0);
    start_i = 1'b0;
    tick();
    do_clear();

    // Mask and pause
    limit_i = '0;
    event_mask_i = 4'b0101;
    event_i = 4'b1111;
    start_i = 1'b1;
    tick();
    ticks(7);
    start_i = 1'b0;
    tick();
    ticks(3);
    check_eq("pause_running", running_o, 0);
    read_cnt(SEL_C, v);
    check_eq("pause_cyc", v, 8);
    start_i = 1'b1;
    ticks(2);
    start_i = 1'b0;
    tick();
    read_cnt(SEL_C, v);
    check_eq("mask_cyc", v, 10);
    read_cnt(0, v);
    check_eq("mask_ev0", v, 10);
    read_cnt(1, v);
    check_eq("mask_ev1", v, 0);
    read_cnt(2, v);
    check_eq("mask_ev2", v, 10);
    read_cnt(3, v);
    check_eq("mask_ev3", v, 0);
    do_clear();

    // Readout latency
    event_i = 4'b0000;
    event_mask_i = 4'b0000;
    rd_sel_i = '0;
    start_i = 1'b1;
    tick();
    ticks(7);
    check_eq("rd_sel0", rd_data_o, 0);
    rd_sel_i = SW'(SEL_C);
    tick();
    check_eq("rd_lat_cyc7", rd_data_o, 7);
    tick();
    check_eq("rd_lat_cyc8", rd_data_o, 8);
    rd_sel_i = 5'd31;
    tick();
    check_eq("rd_sel31", rd_data_o, 0);
    rd_sel_i = 5'd5;
    tick();
    check_eq("rd_sel5", rd_data_o, 0);
    start_i = 1'b0;
    tick();
    do_clear();

    // Saturation on an 8-bit build
    event_mask_i = 4'b1111;
    event_i = 4'b0000;
    event_i[EV_FLUSH] = 1'b1;
    start_i = 1'b1;
    tick();
    ticks(255);
    check_eq("sat_ovf_at_max", ovf_o, 0);
    tick();
    check_eq("sat_ovf_set", ovf_o, 5'b10010);
    ticks(4);
    start_i = 1'b0;
    tick();
    check_eq("sat_ovf_sticky", ovf_o, 5'b10010);
    check_eq("sat_no_halt", halt_o, 0);
    read_cnt(SEL_C, v);
    check_eq("sat_cyc", v, 255);
    read_cnt(1, v);
    check_eq("sat_ev1", v, 255);
    read_cnt(0, v);
    check_eq("sat_ev0", v, 0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_eq("sat_rst_ovf", ovf_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_perf_monitor.md
Name: pipe_perf_monitor

Overview:
- Parametrised cycle/event counter for the pipelined CPU. It generalises the cycle counter, the stall and flush tallies, and the fixed 30-cycle stop into a hardware block.
- Counts run cycles plus NUM_EVENTS qualified event channels (stall, flush, branch-taken, etc.).
- Raises halt_o when a programmable cycle limit is reached.
- Exposes counters through a registered select/readout port. Sits beside the CPU top and is driven by the CPU's start_i and the hazard/control signals.

Parameters:
- NUM_EVENTS, 4, number of event channels (1..16)
- CNT_W, 32, width of every counter, including the cycle counter (8..64)
- SEL_W, 5, width of rd_sel_i; must satisfy 2**SEL_W > NUM_EVENTS

Ports:
- clk_i  in  1  clock; all state updates on its rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  run enable; the same signal that feeds the CPU
- event_i  in  NUM_EVENTS  per-channel raw event strobe, sampled each cycle
- event_mask_i  in  NUM_EVENTS  per-channel enable; an event counts only when event_i[k] & event_mask_i[k]
- limit_i  in  CNT_W  cycle limit; 0 = no limit
- clear_i  in  1  synchronous clear of all counters and flags
- rd_sel_i  in  SEL_W  readout select: 0..NUM_EVENTS-1 = event counter k; NUM_EVENTS = cycle counter
- rd_data_o  out  CNT_W  registered readout of the selected counter
- ovf_o  out  NUM_EVENTS+1  sticky saturation flags; bit NUM_EVENTS = cycle counter
- running_o  out  1  high while in RUN
- halt_o  out  1  high while in HALT

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - state to IDLE; all counters, ovf_o, rd_data_o, running_o and halt_o to 0.
  - rst_i overrides every other input, including mid-RUN.
- States:
  - IDLE:
    - counters hold.
    - start_i=1 -> RUN; the first counting edge is the edge after the transition.
  - RUN:
    - each edge, cyc_cnt += 1 and each qualified event counter += 1.
    - start_i=0 -> IDLE (pause). Counts are preserved and resume on the next start_i=1.
  - HALT:
    - all counters frozen; start_i is ignored.
    - exit only via clear_i or rst_i.
- Limit:
  - in RUN, if limit_i != 0 and (cyc_cnt + 1) == limit_i, that edge performs the final increments and the state goes to HALT.
  - Events asserted in the final cycle are counted.
  - Once halted, cyc_cnt == limit_i exactly.
  - If limit_i is changed to a value <= current cyc_cnt, the block never halts until the counter wraps. The counter does not wrap (see saturation), so it never halts.
- Saturation:
  - a counter at all-ones does not wrap; it holds all-ones.
  - The counter's ovf_o bit sets on the edge where an increment is attempted at all-ones.
  - ovf bits are sticky until clear_i or rst_i.
- clear_i:
  - zeroes all counters and ovf_o; state -> IDLE; halt_o drops next cycle.
  - clear_i beats any same-cycle event or increment.
  - clear_i together with start_i=1 still lands in IDLE; RUN is entered on the following edge if start_i is still 1.
- Readout:
  - rd_data_o <= counter[rd_sel_i] on every edge: one-cycle latency, valid in any state.
  - A select > NUM_EVENTS returns 0.
  - Readout reflects the counter value before that same edge's increment.
- running_o and halt_o are registered state decodes; they are never both 1.
- Widths: all increments are CNT_W-bit unsigned. The limit compare is a CNT_W-bit equality on cyc_cnt+1, computed without widening.

Decomposition:
- Shared package pipe_perf_pkg:
  - state enum {IDLE, RUN, HALT}.
  - Event index constants: EV_STALL=0, EV_FLUSH=1, EV_BRANCH=2, EV_JUMP=3.
  - Default CNT_W.
- One sub-module, perf_sat_counter: parametrised CNT_W saturating counter with inc, clr and sticky ovf.
  - Instantiated NUM_EVENTS+1 times; the extra instance is the cycle counter.

Test Plan:
- Reset mid-RUN:
  - start_i=1 for 10 cycles, then rst_i=1 for 1 cycle -> all counters 0, running_o=0, halt_o=0 on the next edge.
  - rd_sel_i=NUM_EVENTS reads 0.
- Limit halt:
  - limit_i=30, start_i held 1, event_i[0] asserted on cycles 5..9, mask=4'b0001 -> halt_o rises after the 30th counting edge; cyc_cnt=30, ev0=5, ev1..3=0.
  - Further start_i and event activity leaves the values unchanged.
- Mask and pause:
  - event_i=4'b1111 every cycle, mask=4'b0101, run 8 cycles, pause 4 cycles (start_i=0), run 2 more -> cyc=10, ev0=ev2=10, ev1=ev3=0.
- Saturation:
  - CNT_W=8, limit_i=0, event_i[1]=1 for 260 cycles -> ev1=255, cyc=255, ovf_o[1]=1, ovf_o[NUM_EVENTS]=1, other ovf bits 0.
- Clear priority:
  - in HALT, assert clear_i with start_i=1 and event_i=4'b1111 -> next edge: all counters 0, state IDLE, halt_o=0.
  - Following edge: running_o=1.
- Readout latency:
  - cycle 7, rd_sel_i changes 0 -> NUM_EVENTS -> rd_data_o shows the cycle count on the next edge.
  - rd_sel_i=31 -> rd_data_o=0.
